// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response plus the decoder issue handshake.
// The master side is the fetch unit; the slave side is the memory/decoder environment.
interface instr_fetch_unit_if;
    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned INSTR_W = 19;

    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               imem_ack;

    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               instr_ready;

    logic               branch;
    logic               jump;
    logic               call;
    logic               ret;
    logic               cond;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ack,
        output instr,
        output instr_valid,
        input  instr_ready,
        input  branch,
        input  jump,
        input  call,
        input  ret,
        input  cond
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ack,
        input  instr,
        input  instr_valid,
        output instr_ready,
        output branch,
        output jump,
        output call,
        output ret,
        output cond
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: fetches from instruction memory at PC, issues to the decoder,
// and resolves sequential/branch/jump/call/ret next-PC with a 4-entry return stack.
module instr_fetch_unit (
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_unit_if.master bus,
    output logic [2:0]         sp,
    output logic               fault
);
    localparam int unsigned ADDR_W      = 8;
    localparam int unsigned INSTR_W     = 19;
    localparam int unsigned STACK_DEPTH = 4;
    localparam int unsigned SP_W        = 3;
    localparam int unsigned SP_IDX_W    = 2;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] ISSUE = 2'd2;
    localparam logic [1:0] HALT  = 2'd3;

    logic [1:0]                         state_q, state_d;
    logic [ADDR_W-1:0]                  pc_q, pc_d;
    logic [SP_W-1:0]                    sp_q, sp_d;
    logic [STACK_DEPTH-1:0][ADDR_W-1:0] stack_q, stack_d;
    logic [INSTR_W-1:0]                 instr_q, instr_d;
    logic                               instr_valid_q, instr_valid_d;
    logic                               imem_req_q, imem_req_d;
    logic                               fault_q, fault_d;

    logic [ADDR_W-1:0]   pc_inc;
    logic [ADDR_W-1:0]   target;
    logic [ADDR_W-1:0]   stack_top;
    logic [SP_IDX_W-1:0] push_idx;
    logic [SP_IDX_W-1:0] pop_idx;
    logic                stack_full;
    logic                stack_empty;

    // Next-PC candidates and stack pointers; PC arithmetic wraps modulo 256.
    always_comb begin
        pc_inc      = pc_q + ADDR_W'(1);
        target      = instr_q[ADDR_W-1:0];
        push_idx    = SP_IDX_W'(sp_q);
        pop_idx     = SP_IDX_W'(sp_q - SP_W'(1));
        stack_top   = stack_q[pop_idx];
        stack_full  = (sp_q == SP_W'(STACK_DEPTH));
        stack_empty = (sp_q == SP_W'(0));
    end

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        sp_d    = sp_q;
        stack_d = stack_q;
        instr_d = instr_q;
        fault_d = fault_q;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (bus.imem_ack) begin
                    instr_d = bus.imem_rdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.instr_ready) begin
                    state_d = FETCH;
                    if (bus.ret) begin
                        if (stack_empty) begin
                            fault_d = 1'b1;
                            state_d = HALT;
                        end else begin
                            pc_d = stack_top;
                            sp_d = sp_q - SP_W'(1);
                        end
                    end else if (bus.call) begin
                        if (stack_full) begin
                            fault_d = 1'b1;
                            state_d = HALT;
                        end else begin
                            stack_d[push_idx] = pc_inc;
                            sp_d              = sp_q + SP_W'(1);
                            pc_d              = target;
                        end
                    end else if (bus.jump || (bus.branch && bus.cond)) begin
                        pc_d = target;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Request and valid are registered images of the state being entered.
        imem_req_d    = (state_d == FETCH);
        instr_valid_d = (state_d == ISSUE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            sp_q          <= '0;
            stack_q       <= '0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            sp_q          <= sp_d;
            stack_q       <= stack_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            imem_req_q    <= imem_req_d;
            fault_q       <= fault_d;
        end
    end

    assign bus.imem_req    = imem_req_q;
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = instr_valid_q;
    assign sp              = sp_q;
    assign fault           = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scenario bench for instr_fetch_unit: expected fetch addresses and instruction words are
// queued as stimulus is driven and popped when the unit requests/issues.
module tb_instr_fetch_unit;
    localparam int unsigned WAIT_LIMIT = 20;
    localparam logic [4:0] F_NONE = 5'b00000;
    localparam logic [4:0] F_CD   = 5'b00001;
    localparam logic [4:0] F_BR   = 5'b00010;
    localparam logic [4:0] F_JP   = 5'b00100;
    localparam logic [4:0] F_CL   = 5'b01000;
    localparam logic [4:0] F_RT   = 5'b10000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] sp;
    logic       fault;

    int errors = 0;
    int checks = 0;

    logic [7:0]  exp_addr_q[$];
    logic [18:0] exp_instr_q[$];

    instr_fetch_unit_if ifu ();

    instr_fetch_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifu.master),
        .sp    (sp),
        .fault (fault)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        ifu.imem_ack    = 1'b0;
        ifu.imem_rdata  = '0;
        ifu.instr_ready = 1'b0;
        ifu.branch      = 1'b0;
        ifu.jump        = 1'b0;
        ifu.call        = 1'b0;
        ifu.ret         = 1'b0;
        ifu.cond        = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Wait (bounded) for a request, answer it in the same cycle; returns X on timeout.
    task automatic do_fetch(input logic [18:0] word, output logic [7:0] addr_seen);
        int n = 0;
        while (ifu.imem_req !== 1'b1 && n < WAIT_LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (ifu.imem_req !== 1'b1) begin
            addr_seen = 'x;
        end else begin
            addr_seen      = ifu.imem_addr;
            ifu.imem_rdata = word;
            ifu.imem_ack   = 1'b1;
            @(posedge clk);
            @(negedge clk);
            ifu.imem_ack   = 1'b0;
        end
    endtask

    // Wait (bounded) for a valid instruction, accept it with the given decoder flags.
    task automatic do_issue(input logic [4:0] f, output logic [18:0] instr_seen);
        int n = 0;
        while (ifu.instr_valid !== 1'b1 && n < WAIT_LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (ifu.instr_valid !== 1'b1) begin
            instr_seen = 'x;
        end else begin
            instr_seen      = ifu.instr;
            ifu.cond        = f[0];
            ifu.branch      = f[1];
            ifu.jump        = f[2];
            ifu.call        = f[3];
            ifu.ret         = f[4];
            ifu.instr_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            clear_inputs();
        end
    endtask

    function automatic logic [18:0] make_word(input logic [7:0] tgt);
        return {4'($urandom_range(15)), 7'($urandom), tgt};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        checks++; if (ifu.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", ifu.imem_req); end
        checks++; if (ifu.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ifu.instr_valid); end
        checks++; if (ifu.instr !== 19'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", ifu.instr); end
        checks++; if (ifu.imem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h want 00", ifu.imem_addr); end
        checks++; if (sp !== 3'd0) begin errors++; $display("FAIL reset_sp: got %0d want 0", sp); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", fault); end
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        logic [7:0]  a, ea;
        logic [18:0] w, got, ew;
        for (int i = 0; i < 6; i++) begin
            w = make_word(8'($urandom));
            exp_addr_q.push_back(8'(i));
            exp_instr_q.push_back(w);
            do_fetch(w, a);
            do_issue(F_NONE, got);
            ea = exp_addr_q.pop_front();
            ew = exp_instr_q.pop_front();
            checks++; if (a !== ea) begin errors++; $display("FAIL seq_addr[%0d]: got %h want %h", i, a, ea); end
            checks++; if (got !== ew) begin errors++; $display("FAIL seq_instr[%0d]: got %h want %h", i, got, ew); end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0]  a;
        logic [18:0] w, got;
        w = make_word(8'h99);
        do_fetch(w, a);
        checks++; if (a !== 8'h06) begin errors++; $display("FAIL bp_addr: got %h want 06", a); end
        // Hold ready low; a stray ack with different data must not disturb the issued word.
        for (int i = 0; i < 5; i++) begin
            ifu.imem_ack   = 1'b1;
            ifu.imem_rdata = ~w;
            checks++; if (ifu.instr !== w) begin errors++; $display("FAIL bp_instr[%0d]: got %h want %h", i, ifu.instr, w); end
            checks++; if (ifu.instr_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", i, ifu.instr_valid); end
            checks++; if (ifu.imem_req !== 1'b0) begin errors++; $display("FAIL bp_req[%0d]: got %b want 0", i, ifu.imem_req); end
            checks++; if (ifu.imem_addr !== 8'h06) begin errors++; $display("FAIL bp_pc[%0d]: got %h want 06", i, ifu.imem_addr); end
            @(negedge clk);
        end
        clear_inputs();
        do_issue(F_NONE, got);
        checks++; if (got !== w) begin errors++; $display("FAIL bp_issue: got %h want %h", got, w); end
        do_fetch(make_word(8'h00), a);
        checks++; if (a !== 8'h07) begin errors++; $display("FAIL bp_next_addr: got %h want 07", a); end
    endtask

    task automatic test_branch_wrap();
        logic [7:0]  tgt[5];
        logic [4:0]  flg[5];
        logic [7:0]  eadr[5];
        logic [7:0]  a, ea;
        logic [18:0] w, got, ew;
        tgt  = '{8'h05, 8'h20, 8'h20, 8'hFF, 8'h33};
        flg  = '{F_JP, F_BR, F_BR | F_CD, F_JP, F_NONE};
        eadr = '{8'h00, 8'h05, 8'h06, 8'h20, 8'hFF};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            w = make_word(tgt[i]);
            exp_addr_q.push_back(eadr[i]);
            exp_instr_q.push_back(w);
            do_fetch(w, a);
            do_issue(flg[i], got);
            ea = exp_addr_q.pop_front();
            ew = exp_instr_q.pop_front();
            checks++; if (a !== ea) begin errors++; $display("FAIL br_addr[%0d]: got %h want %h", i, a, ea); end
            checks++; if (got !== ew) begin errors++; $display("FAIL br_instr[%0d]: got %h want %h", i, got, ew); end
        end
    endtask

    // Continues from PC wrapped to 00; also exercises ret-over-call and call-over-jump priority.
    task automatic test_call_ret();
        logic [7:0]  tgt[7];
        logic [4:0]  flg[7];
        logic [7:0]  eadr[7];
        logic [2:0]  esp[7];
        logic [7:0]  a, ea;
        logic [18:0] w, got, ew;
        tgt  = '{8'h10, 8'h40, 8'h77, 8'h30, 8'h50, 8'h66, 8'h00};
        flg  = '{F_JP, F_CL, F_RT | F_CL, F_CL | F_JP, F_JP, F_RT, F_NONE};
        eadr = '{8'h00, 8'h10, 8'h40, 8'h11, 8'h30, 8'h50, 8'h12};
        esp  = '{3'd0, 3'd1, 3'd0, 3'd1, 3'd1, 3'd0, 3'd0};
        for (int i = 0; i < 7; i++) begin
            w = make_word(tgt[i]);
            exp_addr_q.push_back(eadr[i]);
            exp_instr_q.push_back(w);
            do_fetch(w, a);
            do_issue(flg[i], got);
            ea = exp_addr_q.pop_front();
            ew = exp_instr_q.pop_front();
            checks++; if (a !== ea) begin errors++; $display("FAIL cr_addr[%0d]: got %h want %h", i, a, ea); end
            checks++; if (got !== ew) begin errors++; $display("FAIL cr_instr[%0d]: got %h want %h", i, got, ew); end
            checks++; if (sp !== esp[i]) begin errors++; $display("FAIL cr_sp[%0d]: got %0d want %0d", i, sp, esp[i]); end
        end
        do_fetch(make_word(8'h00), a);
        checks++; if (a !== 8'h13) begin errors++; $display("FAIL cr_final_addr: got %h want 13", a); end
    endtask

    task automatic test_overflow();
        logic [7:0]  a, ea;
        logic [18:0] w, got;
        logic [2:0]  esp;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            w = make_word(8'((i + 1) * 16));
            exp_addr_q.push_back(8'(i * 16));
            do_fetch(w, a);
            do_issue(F_CL, got);
            ea  = exp_addr_q.pop_front();
            esp = (i < 4) ? 3'(i + 1) : 3'd4;
            checks++; if (a !== ea) begin errors++; $display("FAIL ovf_addr[%0d]: got %h want %h", i, a, ea); end
            checks++; if (sp !== esp) begin errors++; $display("FAIL ovf_sp[%0d]: got %0d want %0d", i, sp, esp); end
            checks++; if (fault !== (i == 4)) begin errors++; $display("FAIL ovf_fault[%0d]: got %b want %b", i, fault, (i == 4)); end
        end
        // HALT must stay frozen and ignore memory acks.
        for (int i = 0; i < 3; i++) begin
            ifu.imem_ack = 1'b1;
            checks++; if (ifu.imem_req !== 1'b0) begin errors++; $display("FAIL halt_req[%0d]: got %b want 0", i, ifu.imem_req); end
            checks++; if (ifu.instr_valid !== 1'b0) begin errors++; $display("FAIL halt_valid[%0d]: got %b want 0", i, ifu.instr_valid); end
            checks++; if (ifu.imem_addr !== 8'h40) begin errors++; $display("FAIL halt_pc[%0d]: got %h want 40", i, ifu.imem_addr); end
            checks++; if (fault !== 1'b1 || sp !== 3'd4) begin errors++; $display("FAIL halt_state[%0d]: got fault=%b sp=%0d want fault=1 sp=4", i, fault, sp); end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    task automatic test_underflow();
        logic [7:0]  a;
        logic [18:0] got;
        do_reset();
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL unf_fault_cleared: got %b want 0", fault); end
        do_fetch(make_word(8'h55), a);
        do_issue(F_RT, got);
        checks++; if (a !== 8'h00) begin errors++; $display("FAIL unf_addr: got %h want 00", a); end
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL unf_fault: got %b want 1", fault); end
        checks++; if (sp !== 3'd0) begin errors++; $display("FAIL unf_sp: got %0d want 0", sp); end
        repeat (2) @(negedge clk);
        checks++; if (ifu.imem_req !== 1'b0 || ifu.instr_valid !== 1'b0) begin errors++; $display("FAIL unf_halt: got req=%b valid=%b want 0 0", ifu.imem_req, ifu.instr_valid); end
        checks++; if (ifu.imem_addr !== 8'h00) begin errors++; $display("FAIL unf_pc: got %h want 00", ifu.imem_addr); end
    endtask

    task automatic test_async_reset();
        logic [7:0]  a;
        logic [18:0] w, got;
        int          n = 0;
        do_reset();
        while (ifu.imem_req !== 1'b1 && n < WAIT_LIMIT) begin
            @(negedge clk);
            n++;
        end
        checks++; if (ifu.imem_req !== 1'b1) begin errors++; $display("FAIL ar_fetch_wait: got req=%b want 1", ifu.imem_req); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ifu.imem_req !== 1'b0) begin errors++; $display("FAIL ar_fetch_req: got %b want 0", ifu.imem_req); end
        checks++; if (ifu.instr_valid !== 1'b0) begin errors++; $display("FAIL ar_fetch_valid: got %b want 0", ifu.instr_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        w = make_word(8'h21);
        do_fetch(w, a);
        checks++; if (a !== 8'h00) begin errors++; $display("FAIL ar_first_addr: got %h want 00", a); end
        checks++; if (ifu.instr_valid !== 1'b1) begin errors++; $display("FAIL ar_issue_wait: got %b want 1", ifu.instr_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ifu.instr_valid !== 1'b0) begin errors++; $display("FAIL ar_issue_valid: got %b want 0", ifu.instr_valid); end
        checks++; if (ifu.instr !== 19'h0) begin errors++; $display("FAIL ar_issue_instr: got %h want 0", ifu.instr); end
        @(negedge clk);
        rst_n = 1'b1;
        do_fetch(make_word(8'h00), a);
        checks++; if (a !== 8'h00) begin errors++; $display("FAIL ar_refetch_addr: got %h want 00", a); end
        do_issue(F_NONE, got);
        checks++; if (got === w) begin errors++; $display("FAIL ar_discard: got %h want not %h", got, w); end
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_sequential();
        test_backpressure();
        test_branch_wrap();
        test_call_ret();
        test_overflow();
        test_underflow();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
